program_loader: RTL and testbench

- Byte-stream program loader; the writer side of the CPU's program memory, which the control unit fetches from.
- Receives a framed byte stream (host or UART front end) and writes the payload into the shared 64 KB byte memory.
- Holds the CPU in reset while loading; releases it on a successful load.
- Sits between the serial front end and the memory write port, muxed ahead of the datapath's memory write.

---
 rtl/program_loader.sv | 177 +++++++++++++++++
 tb/tb_program_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Framed byte-stream loader writing the CPU program memory; holds
//            the CPU in reset until a frame has been fully written.
//            Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module program_loader #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxValid,
  input  logic [7:0]            rxData,
  output logic                  rxReady,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [7:0]            memWriteData,
  output logic                  writeEnableMem,
  output logic                  cpuReset,
  output logic                  loadDone,
  output logic                  loadError
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR_MSB = 4'd1,
    S_ADDR_LSB = 4'd2,
    S_LEN_MSB  = 4'd3,
    S_LEN_LSB  = 4'd4,
    S_DATA     = 4'd5,
    S_CHECK    = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t C_PAYLOAD_END = S_CHECK;
`else
  localparam state_t C_PAYLOAD_END = S_DONE;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             len_q, len_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    rx_ready_q, rx_ready_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic                    w_accept;
  logic                    w_is_header;
  logic [15:0]             w_addr16;
  logic [15:0]             w_len_full;

  assign w_accept    = rxValid & rx_ready_q;
  assign w_is_header = (rxData == HEADER);
  assign w_addr16    = 16'(addr_q);
  assign w_len_full  = {len_q[15:8], rxData};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    we_d        = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rx_ready_d  = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (w_accept) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_is_header) begin
            state_d = S_ADDR_MSB;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
          end
        end
        S_ADDR_MSB: begin
          addr_d  = ADDR_WIDTH'({rxData, w_addr16[7:0]});
          state_d = S_ADDR_LSB;
        end
        S_ADDR_LSB: begin
          addr_d  = ADDR_WIDTH'({w_addr16[15:8], rxData});
          state_d = S_LEN_MSB;
        end
        S_LEN_MSB: begin
          len_d   = {rxData, len_q[7:0]};
          state_d = S_LEN_LSB;
        end
        S_LEN_LSB: begin
          len_d   = w_len_full;
          state_d = (w_len_full == 16'd0) ? C_PAYLOAD_END : S_DATA;
        end
        S_DATA: begin
          // Write is issued from registers next cycle at the pre-increment address.
          we_d        = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rxData;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          len_d       = len_q - 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + rxData;
`endif
          if (len_q == 16'd1) begin
            state_d = C_PAYLOAD_END;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          state_d = (rxData == sum_q) ? S_DONE : S_ERROR;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Release only after a full cycle in DONE, so the last write strobe has
    // already retired; leaving DONE re-asserts on the same edge.
    cpu_reset_d = !((state_q == S_DONE) && (state_d == S_DONE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      rx_ready_q  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      rx_ready_q  <= rx_ready_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rxReady        = rx_ready_q;
  assign memAddress     = mem_addr_q;
  assign memWriteData   = mem_wdata_q;
  assign writeEnableMem = we_q;
  assign cpuReset       = cpu_reset_q;
  assign loadDone       = (state_q == S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign loadError      = (state_q == S_ERROR);
`else
  assign loadError      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Randomized self-checking bench for program_loader against a
//            frame-level reference model (expected writes and final status).
// Revision : 1.0
// ============================================================================
module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady;
  logic [15:0] memAddress;
  logic [7:0]  memWriteData;
  logic        writeEnableMem;
  logic        cpuReset;
  logic        loadDone;
  logic        loadError;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int early_release = 0;
  wr_t wq[$];
  int acc_q[$];

  always #5 clk = ~clk;

  program_loader #(.HEADER(8'hA5), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .rxValid(rxValid), .rxData(rxData),
    .rxReady(rxReady), .memAddress(memAddress), .memWriteData(memWriteData),
    .writeEnableMem(writeEnableMem), .cpuReset(cpuReset),
    .loadDone(loadDone), .loadError(loadError)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: logs every strobe and flags any write seen with the CPU released.
  always @(negedge clk) begin
    if (reset && writeEnableMem) begin
      wq.push_back('{addr: int'(memAddress), data: int'(memWriteData), cyc: cyc});
      if (!cpuReset) early_release++;
    end
  end

  function automatic logic [7:0] sum8(input byte_q_t d);
    int s = 0;
    foreach (d[i]) s += int'(d[i]);
    return s[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit is_data);
    int n = 0;
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    while (!rxReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rxReady) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout byte=%0h rxReady=%0b required=1", b, rxReady);
    end else begin
      @(posedge clk);
      #1;
      if (is_data) acc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rxValid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Sends a frame; stop_after >= 0 returns right after that many data bytes.
  task automatic send_frame(input int addr, input byte_q_t d, input logic [7:0] cks,
                            input int max_gap, input int stop_after);
    int len = d.size();
    send_byte(8'hA5, 1'b0);
    send_byte(8'(addr >> 8), 1'b0);
    send_byte(8'(addr), 1'b0);
    send_byte(8'(len >> 8), 1'b0);
    send_byte(8'(len), 1'b0);
    for (int i = 0; i < len; i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      send_byte(d[i], 1'b1);
      if (max_gap > 0) begin
        int g = $urandom_range(0, max_gap);
        if (g > 0) idle(g);
      end
    end
    if (CKS) send_byte(cks, 1'b0);
    idle(4);
  endtask

  task automatic clear_logs();
    wq.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({rxReady, writeEnableMem, memAddress, memWriteData, cpuReset, loadDone, loadError}
        !== {1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs rdy=%0b we=%0b a=%0h d=%0h cpuRst=%0b done=%0b err=%0b required 0 0 0 0 1 0 0",
               rxReady, writeEnableMem, memAddress, memWriteData, cpuReset, loadDone, loadError);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rxReady !== 1'b1 || cpuReset !== 1'b1) begin
      failures++;
      $display("FAIL reset_release rxReady=%0b cpuReset=%0b required 1 1", rxReady, cpuReset);
    end
  endtask

  task automatic test_basic();
    byte_q_t d = '{8'h10, 8'h20, 8'h30};
    clear_logs();
    send_frame(16'h0100, d, 8'h60, 0, -1);
    checks++;
    if (wq.size() !== 3) begin
      failures++;
      $display("FAIL basic_write_count got=%0d required=3", wq.size());
    end
    foreach (d[i]) if (i < wq.size() && i < acc_q.size()) begin
      checks++;
      if (wq[i].addr !== 16'h0100 + i || wq[i].data !== int'(d[i]) || wq[i].cyc !== acc_q[i]) begin
        failures++;
        $display("FAIL basic_write%0d got a=%0h d=%0h cyc=%0d required a=%0h d=%0h cyc=%0d",
                 i, wq[i].addr, wq[i].data, wq[i].cyc, 16'h0100 + i, d[i], acc_q[i]);
      end
    end
    checks++;
    if (loadDone !== 1'b1 || cpuReset !== 1'b0 || loadError !== 1'b0) begin
      failures++;
      $display("FAIL basic_status done=%0b cpuRst=%0b err=%0b required 1 0 0", loadDone, cpuReset, loadError);
    end
  endtask

  task automatic test_garbage();
    byte_q_t d = '{8'h7E};
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    clear_logs();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    idle(3);
    checks++;
    if (wq.size() !== 0 || cpuReset !== 1'b1 || loadDone !== 1'b0) begin
      failures++;
      $display("FAIL garbage_ignored writes=%0d cpuRst=%0b done=%0b required 0 1 0", wq.size(), cpuReset, loadDone);
    end
    send_frame(16'h0000, d, 8'h7E, 0, -1);
    checks++;
    if (wq.size() !== 1 || (wq.size() == 1 && (wq[0].addr !== 0 || wq[0].data !== 'h7E)) || loadDone !== 1'b1) begin
      failures++;
      $display("FAIL garbage_frame writes=%0d done=%0b required 1 write of 7E@0000 and done=1", wq.size(), loadDone);
    end
  endtask

  task automatic test_wrap();
    byte_q_t d = '{8'hAA, 8'hBB};
    clear_logs();
    send_frame(16'hFFFF, d, 8'h65, 0, -1);
    checks++;
    if (wq.size() !== 2 || (wq.size() == 2 && (wq[0].addr !== 'hFFFF || wq[0].data !== 'hAA ||
        wq[1].addr !== 'h0000 || wq[1].data !== 'hBB))) begin
      failures++;
      $display("FAIL wrap_writes count=%0d required AA@FFFF then BB@0000", wq.size());
    end
  endtask

  task automatic test_zero_len();
    byte_q_t d = {};
    clear_logs();
    send_frame(16'h1234, d, 8'h00, 0, -1);
    checks++;
    if (wq.size() !== 0 || loadDone !== 1'b1 || cpuReset !== 1'b0) begin
      failures++;
      $display("FAIL zero_len writes=%0d done=%0b cpuRst=%0b required 0 1 0", wq.size(), loadDone, cpuReset);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t d = '{8'h01, 8'h02};
    byte_q_t g = '{8'h09};
    clear_logs();
    send_frame(16'h0010, d, 8'h04, 0, -1);
    checks++;
    if (wq.size() !== 2 || (wq.size() == 2 && (wq[0].addr !== 'h10 || wq[0].data !== 1 ||
        wq[1].addr !== 'h11 || wq[1].data !== 2))) begin
      failures++;
      $display("FAIL cks_bad_writes count=%0d required 01@0010 02@0011", wq.size());
    end
    checks++;
    if (loadError !== 1'b1 || loadDone !== 1'b0 || cpuReset !== 1'b1) begin
      failures++;
      $display("FAIL cks_bad_status err=%0b done=%0b cpuRst=%0b required 1 0 1", loadError, loadDone, cpuReset);
    end
    send_frame(16'h0020, g, 8'h09, 0, -1);
    checks++;
    if (loadError !== 1'b0 || loadDone !== 1'b1 || cpuReset !== 1'b0) begin
      failures++;
      $display("FAIL cks_recover err=%0b done=%0b cpuRst=%0b required 0 1 0", loadError, loadDone, cpuReset);
    end
  endtask
`endif

  task automatic test_reset_mid();
    byte_q_t d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    clear_logs();
    send_frame(16'h0300, d, sum8(d), 0, 2);
    @(negedge clk);
    rxValid = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({rxReady, writeEnableMem, memAddress, memWriteData, cpuReset, loadDone, loadError}
        !== {1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_outputs rdy=%0b we=%0b a=%0h d=%0h cpuRst=%0b done=%0b err=%0b required 0 0 0 0 1 0 0",
               rxReady, writeEnableMem, memAddress, memWriteData, cpuReset, loadDone, loadError);
    end
    checks++;
    if (wq.size() !== 2 || (wq.size() == 2 && (wq[0].addr !== 'h300 || wq[1].addr !== 'h301))) begin
      failures++;
      $display("FAIL midreset_partial writes=%0d required 2 (0300,0301)", wq.size());
    end
    // Bytes offered while held in reset must not be consumed.
    rxValid = 1'b1;
    rxData  = 8'hA5;
    repeat (2) @(negedge clk);
    rxValid = 1'b0;
    reset   = 1'b1;
    clear_logs();
    send_frame(16'h0400, d, sum8(d), 0, -1);
    checks++;
    if (wq.size() !== 4 || loadDone !== 1'b1 || cpuReset !== 1'b0) begin
      failures++;
      $display("FAIL midreset_reload writes=%0d done=%0b cpuRst=%0b required 4 1 0", wq.size(), loadDone, cpuReset);
    end
    foreach (d[i]) if (i < wq.size()) begin
      checks++;
      if (wq[i].addr !== 'h400 + i || wq[i].data !== int'(d[i])) begin
        failures++;
        $display("FAIL midreset_write%0d got a=%0h d=%0h required a=%0h d=%0h",
                 i, wq[i].addr, wq[i].data, 'h400 + i, d[i]);
      end
    end
  endtask

  task automatic test_restart_header();
    clear_logs();
    checks++;
    if (cpuReset !== 1'b0 || loadDone !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre cpuRst=%0b done=%0b required 0 1", cpuReset, loadDone);
    end
    send_byte(8'hA5, 1'b0);
    checks++;
    if (cpuReset !== 1'b1 || loadDone !== 1'b0) begin
      failures++;
      $display("FAIL restart_accept cpuRst=%0b done=%0b required 1 0", cpuReset, loadDone);
    end
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b1);
    if (CKS) send_byte(8'h55, 1'b0);
    idle(4);
    checks++;
    if (wq.size() !== 1 || (wq.size() == 1 && (wq[0].addr !== 'h200 || wq[0].data !== 'h55)) || loadDone !== 1'b1) begin
      failures++;
      $display("FAIL restart_frame writes=%0d done=%0b required 55@0200 done=1", wq.size(), loadDone);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      byte_q_t d = {};
      int  a   = int'($urandom_range(0, 65535));
      int  len = int'($urandom_range(0, 7));
      bit  bad = CKS && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      clear_logs();
      send_frame(a, d, sum8(d) + 8'(bad), 2, -1);
      checks++;
      if (wq.size() !== len) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d required=%0d", f, wq.size(), len);
      end
      foreach (d[i]) if (i < wq.size() && i < acc_q.size()) begin
        checks++;
        if (wq[i].addr !== ((a + i) & 'hFFFF) || wq[i].data !== int'(d[i]) || wq[i].cyc !== acc_q[i]) begin
          failures++;
          $display("FAIL rand%0d_write%0d got a=%0h d=%0h cyc=%0d required a=%0h d=%0h cyc=%0d", f, i,
                   wq[i].addr, wq[i].data, wq[i].cyc, (a + i) & 'hFFFF, d[i], acc_q[i]);
        end
      end
      checks++;
      if (loadDone !== !bad || loadError !== bad || cpuReset !== bad) begin
        failures++;
        $display("FAIL rand%0d_status done=%0b err=%0b cpuRst=%0b required %0b %0b %0b",
                 f, loadDone, loadError, cpuReset, !bad, bad, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_wrap();
    test_zero_len();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_restart_header();
    test_random();
    checks++;
    if (early_release !== 0) begin
      failures++;
      $display("FAIL release_order writes_with_cpu_released=%0d required=0", early_release);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
